// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one uart_tx between several
// word sources. A winning source is accepted with a one-cycle ready pulse, its
// word is latched and sent with a single send pulse, optionally preceded by a
// tag word carrying the source index. The arbiter then waits for uart_tx to
// report the frame done before it accepts the next word.
module uart_tx_arb #(
    parameter int p_NUM_REQ  = 4,
    parameter int p_WORD_LEN = 8,
    parameter int p_TAG_EN   = 0
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [p_NUM_REQ-1:0]              i_req_valid,
    input  logic [p_NUM_REQ*p_WORD_LEN-1:0]   i_req_data,
    output logic [p_NUM_REQ-1:0]              o_req_ready,
    output logic                              o_send_en,
    output logic [p_WORD_LEN-1:0]             o_send_data,
    input  logic                              i_send_rdy,
    output logic                              o_busy,
    output logic [$clog2(p_NUM_REQ)-1:0]      o_grant_id
);

    localparam int IDX_W  = $clog2(p_NUM_REQ);
    localparam int CAND_W = IDX_W + 1;
    localparam logic [CAND_W-1:0] NUM_REQ_C = CAND_W'(p_NUM_REQ);
    localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(p_NUM_REQ - 1);

    // Configurations that cannot work are rejected at elaboration time.
    generate
        if (p_NUM_REQ < 2) begin : g_badNumReq
            $error("uart_tx_arb: p_NUM_REQ must be at least 2");
        end
        if ((p_TAG_EN != 0) && (IDX_W > p_WORD_LEN)) begin : g_badTagWidth
            $error("uart_tx_arb: source index does not fit in a tag word");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_WAIT_TAG,
        S_DATA,
        S_WAIT_DATA
    } StateT;

    StateT                 state_q;
    logic [IDX_W-1:0]      last_q;
    logic [IDX_W-1:0]      grant_q;
    logic [p_WORD_LEN-1:0] word_q;
    logic [p_WORD_LEN-1:0] sendData_q;
    logic                  sendEn_q;
    logic                  busy_q;
    logic                  firstWait_q;

    logic [IDX_W-1:0]      winner;
    logic                  anyValid;
    logic [CAND_W-1:0]     cand;
    logic [p_WORD_LEN-1:0] winnerData;
    logic [p_WORD_LEN-1:0] tagWord;
    logic                  accept;

    // Round-robin search: first valid source after the previous winner, with wrap.
    always_comb begin
        winner   = '0;
        anyValid = 1'b0;
        cand     = '0;
        for (int i = 1; i <= p_NUM_REQ; i++) begin
            cand = {1'b0, last_q} + CAND_W'(i);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!anyValid && i_req_valid[cand[IDX_W-1:0]]) begin
                anyValid = 1'b1;
                winner   = cand[IDX_W-1:0];
            end
        end
    end

    // Select the winning source's word from the packed data bus.
    always_comb begin
        winnerData = '0;
        for (int k = 0; k < p_NUM_REQ; k++) begin
            if (winner == IDX_W'(k)) begin
                winnerData = i_req_data[k*p_WORD_LEN +: p_WORD_LEN];
            end
        end
    end

    // The tag word is the winner index zero-extended to a full word.
    generate
        if (IDX_W < p_WORD_LEN) begin : g_tagPad
            assign tagWord = {{(p_WORD_LEN-IDX_W){1'b0}}, winner};
        end else begin : g_tagFit
            assign tagWord = winner[p_WORD_LEN-1:0];
        end
    endgenerate

    // A word is taken only while idle, out of reset, with uart_tx ready.
    assign accept = i_rst_n && (state_q == S_IDLE) && anyValid && i_send_rdy;

    // Ready goes only to the winner and only in the accept cycle.
    always_comb begin
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    // Arbiter FSM with registered send/busy/grant outputs. Send pulses are
    // launched on the transition into S_TAG/S_DATA so they last one cycle, and
    // the first cycle of each wait state is skipped because uart_tx has not yet
    // reacted to the pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= LAST_INIT;
            grant_q     <= '0;
            word_q      <= '0;
            sendData_q  <= '0;
            sendEn_q    <= 1'b0;
            busy_q      <= 1'b0;
            firstWait_q <= 1'b0;
        end else begin
            sendEn_q   <= 1'b0;
            sendData_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        word_q   <= winnerData;
                        grant_q  <= winner;
                        last_q   <= winner;
                        busy_q   <= 1'b1;
                        sendEn_q <= 1'b1;
                        if (p_TAG_EN != 0) begin
                            state_q    <= S_TAG;
                            sendData_q <= tagWord;
                        end else begin
                            state_q    <= S_DATA;
                            sendData_q <= winnerData;
                        end
                    end
                end
                S_TAG: begin
                    state_q     <= S_WAIT_TAG;
                    firstWait_q <= 1'b1;
                end
                S_WAIT_TAG: begin
                    if (firstWait_q) begin
                        firstWait_q <= 1'b0;
                    end else if (i_send_rdy) begin
                        state_q    <= S_DATA;
                        sendEn_q   <= 1'b1;
                        sendData_q <= word_q;
                    end
                end
                S_DATA: begin
                    state_q     <= S_WAIT_DATA;
                    firstWait_q <= 1'b1;
                end
                S_WAIT_DATA: begin
                    if (firstWait_q) begin
                        firstWait_q <= 1'b0;
                    end else if (i_send_rdy) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    firstWait_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_send_en   = sendEn_q;
    assign o_send_data = sendData_q;
    assign o_busy      = busy_q;
    assign o_grant_id  = grant_q;

endmodule
